// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int PKT_COUNT_WIDTH    = 16;
    function automatic int id_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: first set request at or after i_ptr, wrapping modulo N.
module rr_priority_select
    import fifo_arb_pkg::*;
#(
    parameter int N = DEFAULT_NUM_REQ,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);
    localparam logic [IW:0] N_W = (IW+1)'(N);
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_first;
    logic [IW:0]    w_sum;
    // Rotate so i_ptr lands at bit 0, pick the lowest set bit, rotate the index back.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N-1:0];
    always_comb begin
        o_found = 1'b0;
        w_first = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_first = k[IW-1:0];
            end
        end
        w_sum = {1'b0, w_first} + {1'b0, i_ptr};
        o_idx = (w_sum >= N_W) ? IW'(w_sum - N_W) : w_sum[IW-1:0];
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-locked round-robin sharing of one FIFO write port.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int IW = id_width(NUM_REQ)
) (
    input  logic                          i_clock,
    input  logic                          i_clear_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_write,
    output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
    input  logic                          i_fifo_full,
    output logic [IW-1:0]                 o_grant_id,
    output logic                          o_busy,
    output logic [PKT_COUNT_WIDTH-1:0]    o_pkt_count
);
    arb_state_t                 r_state, w_state_nxt;
    logic [IW-1:0]              r_owner, r_rr_ptr, r_grant_id;
    logic [IW-1:0]              w_sel_idx, w_cand, w_ptr_nxt;
    logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;
    logic                       w_found, w_xfer, w_last;

    rr_priority_select #(.N(NUM_REQ)) u_sel (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_sel_idx)
    );

    // While a packet is open only its owner is considered.
    assign w_cand    = (r_state == LOCKED) ? r_owner : w_sel_idx;
    assign w_xfer    = i_clear_n && !i_fifo_full && i_req_valid[w_cand] && (r_state == LOCKED || w_found);
    assign w_last    = i_req_last[w_cand];
    assign w_ptr_nxt = (w_cand == IW'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;

    always_ff @(posedge i_clock) begin
        r_state <= !i_clear_n ? IDLE : w_state_nxt;
    end

    always_comb begin
        w_state_nxt = !w_xfer ? r_state : (w_last ? IDLE : LOCKED);
    end

    always_comb begin
        o_req_ready    = w_xfer ? NUM_REQ'(1) << w_cand : '0;
        o_fifo_write   = w_xfer;
        o_fifo_data_in = w_xfer ? i_req_data[w_cand*DATA_WIDTH +: DATA_WIDTH] : '0;
        o_busy         = (r_state == LOCKED);
        o_grant_id     = r_grant_id;
        o_pkt_count    = r_pkt_count;
    end

    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_pkt_count <= '0;
        end else if (w_xfer) begin
            r_owner    <= w_cand;
            r_grant_id <= w_cand;
            if (w_last) begin
                r_rr_ptr    <= w_ptr_nxt;
                r_pkt_count <= r_pkt_count + 1'b1;
            end
        end
    end
endmodule
